traffic_phase_sched: RTL and testbench

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/tick_gen.sv | 27 ++
 rtl/traffic_phase_sched.sv | 140 ++++++++++++++
 tb/tb_traffic_phase_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase scheduler: state encodings,
// lamp patterns and default timing. The early-termination option is TRAFFIC_REQ_EARLY_EN.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_G1    = 3'd0,
        ST_Y1    = 3'd1,
        ST_AR1   = 3'd2,
        ST_G2    = 3'd3,
        ST_Y2    = 3'd4,
        ST_AR2   = 3'd5,
        ST_FLASH = 3'd6
    } state_e;

    // Lamp vector bit order: {red1, yellow1, green1, red2, yellow2, green2}
    localparam logic [5:0] LAMP_G1 = 6'b001_100;
    localparam logic [5:0] LAMP_Y1 = 6'b010_100;
    localparam logic [5:0] LAMP_AR = 6'b100_100;
    localparam logic [5:0] LAMP_G2 = 6'b100_001;
    localparam logic [5:0] LAMP_Y2 = 6'b100_010;

    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_GREEN_T     = 30;
    localparam int DEF_YELLOW_T    = 3;
    localparam int DEF_ALLRED_T    = 2;
    localparam int DEF_MIN_GREEN_T = 8;

    function automatic logic [5:0] lamp_pattern(input state_e st, input logic flash);
        case (st)
            ST_G1:    lamp_pattern = LAMP_G1;
            ST_Y1:    lamp_pattern = LAMP_Y1;
            ST_G2:    lamp_pattern = LAMP_G2;
            ST_Y2:    lamp_pattern = LAMP_Y2;
            ST_FLASH: lamp_pattern = {1'b0, flash, 1'b0, 1'b0, flash, 1'b0};
            default:  lamp_pattern = LAMP_AR;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-clock tick every TICK_DIV clocks; the first tick
// arrives TICK_DIV clocks after reset release.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q + PW'(1);
        if (pre_q == PRE_LAST) pre_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pre_q <= '0;
        else         pre_q <= pre_d;
    end

    assign tick_o = (pre_q == PRE_LAST);

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-direction traffic light phase scheduler with night-flash mode.
// Define TRAFFIC_REQ_EARLY_EN to enable request-driven early green termination.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int GREEN_T     = DEF_GREEN_T,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int ALLRED_T    = DEF_ALLRED_T,
    parameter int MIN_GREEN_T = DEF_MIN_GREEN_T
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    input  logic       Req1,
    input  logic       Req2,
    output logic       Red1,
    output logic       Yellow1,
    output logic       Green1,
    output logic       Red2,
    output logic       Yellow2,
    output logic       Green2,
    output logic [2:0] Phase
);
    localparam int CNT_W = $clog2(max3(GREEN_T, YELLOW_T, ALLRED_T) + 1);
    localparam logic [CNT_W-1:0] GREEN_END  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flash_q, flash_d;
    logic [5:0]       lamp_q;
    logic [1:0]       sw_sync_q;
    logic             sw_s;
    logic             tick;
    logic             early1, early2;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk_i  (CLK),
        .rst_ni (RST),
        .tick_o (tick)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sw_sync_q <= '0;
        else      sw_sync_q <= {sw_sync_q[0], SW1};
    end
    assign sw_s = sw_sync_q[1];

    // All decisions happen on ticks; any state change clears cnt and sets the flash phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (tick) begin
            cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                ST_G1:    if (!sw_s || cnt_q == GREEN_END || early1) state_d = ST_Y1;
                ST_Y1:    if (cnt_q == YELLOW_END) state_d = sw_s ? ST_AR1 : ST_FLASH;
                ST_AR1:   if (!sw_s) state_d = ST_FLASH;
                          else if (cnt_q == ALLRED_END) state_d = ST_G2;
                ST_G2:    if (!sw_s || cnt_q == GREEN_END || early2) state_d = ST_Y2;
                ST_Y2:    if (cnt_q == YELLOW_END) state_d = sw_s ? ST_AR2 : ST_FLASH;
                ST_AR2:   if (!sw_s) state_d = ST_FLASH;
                          else if (cnt_q == ALLRED_END) state_d = ST_G1;
                ST_FLASH: if (sw_s) state_d = ST_AR2;
                          else flash_d = ~flash_q;
                default:  state_d = ST_AR2;
            endcase
        end
        if (state_d != state_q) begin
            cnt_d   = '0;
            flash_d = (state_d == ST_FLASH);
        end
    end

    // Lamps are registered from the next state so they switch on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_AR2;
            cnt_q   <= '0;
            flash_q <= 1'b0;
            lamp_q  <= LAMP_AR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            lamp_q  <= lamp_pattern(state_d, flash_d);
        end
    end

`ifdef TRAFFIC_REQ_EARLY_EN
    localparam logic [CNT_W-1:0] MIN_END = CNT_W'(MIN_GREEN_T - 1);

    logic [1:0] req1_sync_q, req2_sync_q;
    logic       pend1_q, pend1_d, pend2_q, pend2_d;

    // Clearing on entry to the served green (or FLASH) overrides a same-cycle set.
    always_comb begin
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        if (state_q != ST_FLASH) begin
            if (req1_sync_q[1]) pend1_d = 1'b1;
            if (req2_sync_q[1]) pend2_d = 1'b1;
        end
        if (state_d != state_q) begin
            if (state_d == ST_G1 || state_d == ST_FLASH) pend1_d = 1'b0;
            if (state_d == ST_G2 || state_d == ST_FLASH) pend2_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req1_sync_q <= '0;
            req2_sync_q <= '0;
            pend1_q     <= 1'b0;
            pend2_q     <= 1'b0;
        end else begin
            req1_sync_q <= {req1_sync_q[0], Req1};
            req2_sync_q <= {req2_sync_q[0], Req2};
            pend1_q     <= pend1_d;
            pend2_q     <= pend2_d;
        end
    end

    assign early1 = pend2_q & ~pend1_q & (cnt_q >= MIN_END);
    assign early2 = pend1_q & ~pend2_q & (cnt_q >= MIN_END);
`else
    localparam int unused_min_green = MIN_GREEN_T;
    logic unused_req;
    assign unused_req = Req1 ^ Req2;
    assign early1     = 1'b0;
    assign early2     = 1'b0;
`endif

    assign {Red1, Yellow1, Green1, Red2, Yellow2, Green2} = lamp_q;
    assign Phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: phase-duration scoreboard, lamp table and
// hand-written flash / mid-phase reset sequences.
module tb_traffic_phase_sched;
    import traffic_pkg::*;

    localparam int W = 11;
`ifdef TRAFFIC_REQ_EARLY_EN
    localparam int G1_EARLY = 16;
`else
    localparam int G1_EARLY = 40;
`endif

    logic       CLK, RST, SW1, Req1, Req2;
    logic       Red1, Yellow1, Green1, Red2, Yellow2, Green2;
    logic [2:0] Phase;

    traffic_phase_sched #(
        .TICK_DIV(4), .GREEN_T(10), .YELLOW_T(3), .ALLRED_T(2), .MIN_GREEN_T(4)
    ) dut (
        .CLK(CLK), .RST(RST), .SW1(SW1), .Req1(Req1), .Req2(Req2),
        .Red1(Red1), .Yellow1(Yellow1), .Green1(Green1),
        .Red2(Red2), .Yellow2(Yellow2), .Green2(Green2),
        .Phase(Phase)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct { logic [2:0] ph; logic [5:0] lamps; } lamp_vec_t;
    typedef struct { int scen; logic [2:0] ph; int clks; } seg_t;

    lamp_vec_t      lamp_tbl[6];
    seg_t           seg_tbl[$];
    logic [W-1:0]   exp_q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    logic           mon_en = 1'b0;
    logic [2:0]     last_ph;
    int             run_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] lamps_now();
        return {Red1, Yellow1, Green1, Red2, Yellow2, Green2};
    endfunction

    // scoreboard: segment = {phase, clocks spent in it}
    always @(negedge CLK) begin
        logic       ok;
        logic [5:0] exp_l;
        int         s1, s2;
        s1 = int'(Red1) + int'(Yellow1) + int'(Green1);
        s2 = int'(Red2) + int'(Yellow2) + int'(Green2);
        if (Phase == 3'd6)
            ok = !Red1 && !Green1 && !Red2 && !Green2 && (Yellow1 == Yellow2);
        else
            ok = !((Green1 | Yellow1) & (Green2 | Yellow2)) && (s1 == 1) && (s2 == 1);
        chk("lamp_invariant", 32'(ok), 32'(1));
        if (mon_en) begin
            if (Phase != 3'd6) begin
                exp_l = 6'bx;
                for (int i = 0; i < 6; i++)
                    if (lamp_tbl[i].ph == Phase) exp_l = lamp_tbl[i].lamps;
                chk("lamp_decode", 32'(lamps_now()), 32'(exp_l));
            end
            if (Phase !== last_ph) begin
                if (exp_q.size() > 0) begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("segment", 32'({last_ph, 8'(run_len)}), 32'(e));
                end
                last_ph = Phase;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    // driver tasks
    task automatic add_seg(input int s, input logic [2:0] ph, input int clks);
        seg_t e;
        e.scen = s; e.ph = ph; e.clks = clks;
        seg_tbl.push_back(e);
    endtask

    task automatic push_scen(input int s);
        foreach (seg_tbl[i])
            if (seg_tbl[i].scen == s) exp_q.push_back({seg_tbl[i].ph, 8'(seg_tbl[i].clks)});
    endtask

    task automatic start_mon();
        last_ph = 3'd5;
        run_len = 0;
        mon_en  = 1'b1;
    endtask

    // Release lands 1 time unit after a posedge ("edge 0").
    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0; SW1 = 1'b1; Req1 = 1'b0; Req2 = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_phase", 32'(Phase), 32'd5);
        chk("reset_lamps", 32'(lamps_now()), 32'(6'b100_100));
        @(posedge CLK); #1;
        RST = 1'b1;
        start_mon();
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d segments still pending after %0d clk", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        RST = 1'b0; SW1 = 1'b1; Req1 = 1'b0; Req2 = 1'b0;

        lamp_tbl[0] = '{3'd0, 6'b001_100};
        lamp_tbl[1] = '{3'd1, 6'b010_100};
        lamp_tbl[2] = '{3'd2, 6'b100_100};
        lamp_tbl[3] = '{3'd3, 6'b100_001};
        lamp_tbl[4] = '{3'd4, 6'b100_010};
        lamp_tbl[5] = '{3'd5, 6'b100_100};

        // 1: plain cycle; 2: Req2 pulse in G1; 3: both requests held;
        // 4: Req1 cleared on G1 entry then Req2; 5: night flash; 6: reset mid-Y1
        add_seg(1, 3'd5, 8);  add_seg(1, 3'd0, 40); add_seg(1, 3'd1, 12);
        add_seg(1, 3'd2, 8);  add_seg(1, 3'd3, 40); add_seg(1, 3'd4, 12);
        add_seg(1, 3'd5, 8);
        add_seg(2, 3'd5, 8);  add_seg(2, 3'd0, G1_EARLY); add_seg(2, 3'd1, 12);
        add_seg(3, 3'd5, 8);  add_seg(3, 3'd0, 40); add_seg(3, 3'd1, 12);
        add_seg(3, 3'd2, 8);  add_seg(3, 3'd3, 40);
        add_seg(4, 3'd5, 8);  add_seg(4, 3'd0, G1_EARLY);
        add_seg(5, 3'd5, 8);  add_seg(5, 3'd0, 40); add_seg(5, 3'd1, 12);
        add_seg(5, 3'd2, 8);  add_seg(5, 3'd3, 12); add_seg(5, 3'd4, 12);
        add_seg(5, 3'd6, 16); add_seg(5, 3'd5, 8);
        add_seg(6, 3'd5, 8);  add_seg(6, 3'd0, 40);

        do_reset();
        push_scen(1);
        wait_empty("normal_cycle", 300);

        do_reset();
        push_scen(2);
        repeat (10) @(posedge CLK); #1 Req2 = 1'b1;
        @(posedge CLK); #1 Req2 = 1'b0;
        wait_empty("req2_early", 200);

        do_reset();
        Req1 = 1'b1; Req2 = 1'b1;
        push_scen(3);
        wait_empty("both_pending", 300);
        Req1 = 1'b0; Req2 = 1'b0;

        do_reset();
        push_scen(4);
        @(posedge CLK); #1 Req1 = 1'b1;
        @(posedge CLK); #1 Req1 = 1'b0;
        repeat (8) @(posedge CLK); #1 Req2 = 1'b1;
        @(posedge CLK); #1 Req2 = 1'b0;
        wait_empty("pend1_clear", 200);

        // night flash entered from mid-G2; yellows toggle every 4 clk
        do_reset();
        push_scen(5);
        repeat (77) @(posedge CLK); #1 SW1 = 1'b0;
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        chk("flash_phase", 32'(Phase), 32'd6);
        chk("flash_on_entry", 32'({Yellow1, Yellow2}), 32'(2'b11));
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("flash_toggle_off", 32'({Yellow1, Yellow2}), 32'(2'b00));
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("flash_toggle_on", 32'({Yellow1, Yellow2}), 32'(2'b11));
        @(posedge CLK); #1 SW1 = 1'b1;
        wait_empty("flash_exit", 200);

        // one-clock reset pulse in the middle of Y1
        do_reset();
        push_scen(6);
        repeat (52) @(posedge CLK); #1;
        RST = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midreset_phase", 32'(Phase), 32'd5);
        chk("midreset_lamps", 32'(lamps_now()), 32'(6'b100_100));
        chk("midreset_prior_segs", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        start_mon();
        push_scen(6);
        wait_empty("restart_after_reset", 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
